gradient_seq_ctrl: RTL and testbench
====================================

Name: gradient_seq_ctrl

Overview:
- Sequencer for a two-inlet, N-output serpentine gradient generator.
- Primes the network, then opens one output port at a time in a programmable order (ascending, descending or ping-pong).
- At each port it waits a dwell time, requests a sample from the downstream sensor, and waits for acknowledgement before moving on.
- Sits between the host control register block and the inlet/outlet valve drivers of the gradient generator array.

Parameters:
- N_OUT, 11, number of gradient outputs (>=2)
- DWELL_W, 16, width of the prime and dwell cycle counts
- REP_W, 4, width of the pass-repeat count
- ACK_TO, 1024, maximum cycles sample_req may wait for sample_ack
- IDX_W, $clog2(N_OUT), width of the channel index

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; sampled only in IDLE
- abort  in  1  terminate the sequence immediately
- mode  in  2  00 ascending, 01 descending, 10 ping-pong, 11 treated as ascending
- prime_cyc  in  DWELL_W  flush length in cycles; 0 skips PRIME
- dwell_cyc  in  DWELL_W  settle cycles per port; 0 treated as 1
- passes  in  REP_W  number of full passes; 0 treated as 1
- inlet_en  out  2  inlet valve enables [1]=B, [0]=A
- out_valve  out  N_OUT  outlet valve enables
- chan_idx  out  IDX_W  currently selected port
- sample_req  out  1  sensor sample request
- sample_ack  in  1  sensor acknowledge
- busy  out  1  sequence active
- done  out  1  one-cycle completion pulse
- err  out  1  sticky ack-timeout flag, cleared on the next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; all counters 0; config registers 0.
- IDLE:
  - start=1 latches mode, prime_cyc, dwell_cyc and passes, and clears err.
  - Next cycle the state is PRIME, or SETTLE if prime_cyc=0.
- PRIME: lasts exactly prime_cyc cycles; inlet_en=11; out_valve=all ones (flush); chan_idx=0; busy=1.
- SETTLE: lasts max(dwell_cyc,1) cycles; inlet_en=11; out_valve=one-hot(chan_idx); sample_req=0.
- REQ:
  - sample_req=1; outputs otherwise as in SETTLE.
  - The cycle sample_ack=1 is seen: the next cycle is SETTLE on the next port, or DONE after the last visit of the last pass. sample_req drops in that next cycle.
  - A 1-cycle ack already high on REQ entry is accepted.
- Ack timeout: if sample_req has been high ACK_TO cycles with no ack, err<=1 and the next state is DONE.
- DONE: one cycle; done=1; busy=0; inlet_en=0; out_valve=0; sample_req=0. Then IDLE.
- Visit order per pass:
  - Ascending: 0..N_OUT-1.
  - Descending: N_OUT-1..0.
  - Ping-pong: 0..N_OUT-1, then N_OUT-2..0, giving 2*N_OUT-1 visits per pass.
  - Each new pass restarts from the mode's first index. PRIME runs only once per start.
- Pass counter increments at the end of each pass; the sequence completes when it equals the latched passes value.
- abort=1 in any non-IDLE state: next cycle IDLE; all outputs 0; done not pulsed; err unchanged. abort wins over simultaneous sample_ack or timeout.
- start while busy: ignored, and config inputs are not re-latched.
- Simultaneous start and abort in IDLE: start is ignored.
- Counters saturate or wrap only within their declared widths; the dwell counter is DWELL_W bits; the timeout counter is $clog2(ACK_TO+1) bits.
- Exactly one out_valve bit is high in SETTLE/REQ; none in IDLE/DONE.

Test Plan:
- Ascending: N_OUT=11, prime=2, dwell=3, passes=1, ack returned 1 cycle after every req.
  - PRIME lasts 2 cycles with out_valve=0x7FF.
  - 11 visits, chan_idx 0..10, each SETTLE exactly 3 cycles.
  - One done pulse; busy low afterwards.
- Ping-pong: passes=2, prime=0, dwell=0.
  - 42 sample_req handshakes, order 0..10,9..0, repeated.
  - SETTLE is 1 cycle each; no PRIME state.
- Ack timeout: ACK_TO=8, sample_ack held 0.
  - sample_req stays high 8 cycles, then err=1, done pulses, all valves 0.
  - err clears on the next start.
- Abort during REQ coincident with sample_ack: next cycle IDLE, outputs 0, no done, chan_idx=0.
- start pulsed while busy with a different mode: order unchanged.
- Descending: N_OUT=4, passes=1: visit order 3,2,1,0.
- Async reset asserted mid-SETTLE: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gradient_seq_ctrl.sv
// ============================================================================
// Module   : gradient_seq_ctrl
// Brief    : Prime / dwell / sample sequencer for a serpentine gradient array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gradient_seq_ctrl #(
    parameter int N_OUT   = 11,
    parameter int DWELL_W = 16,
    parameter int REP_W   = 4,
    parameter int ACK_TO  = 1024,
    parameter int IDX_W   = $clog2(N_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] prime_cyc,
    input  logic [DWELL_W-1:0] dwell_cyc,
    input  logic [REP_W-1:0]   passes,
    output logic [1:0]         inlet_en,
    output logic [N_OUT-1:0]   out_valve,
    output logic [IDX_W-1:0]   chan_idx,
    output logic               sample_req,
    input  logic               sample_ack,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int               c_TO_W      = $clog2(ACK_TO + 1);
    localparam logic [2:0]       c_S_IDLE    = 3'd0;
    localparam logic [2:0]       c_S_PRIME   = 3'd1;
    localparam logic [2:0]       c_S_SETTLE  = 3'd2;
    localparam logic [2:0]       c_S_REQ     = 3'd3;
    localparam logic [2:0]       c_S_DONE    = 3'd4;
    localparam logic [1:0]       c_MODE_DESC = 2'b01;
    localparam logic [1:0]       c_MODE_PP   = 2'b10;
    localparam logic [IDX_W-1:0] c_LAST      = IDX_W'(N_OUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(ACK_TO - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [1:0]         r_mode;
    logic [DWELL_W-1:0] r_prime;
    logic [DWELL_W-1:0] r_dwell;
    logic [REP_W-1:0]   r_passes;
    logic [DWELL_W-1:0] r_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_dir;
    logic [REP_W-1:0]   r_pass_cnt;
    logic               r_err;

    logic               w_abort;
    logic               w_accept;
    logic [DWELL_W-1:0] w_prime_last;
    logic [DWELL_W-1:0] w_dwell_last;
    logic [REP_W:0]     w_passes_eff;
    logic [REP_W:0]     w_pass_inc;
    logic               w_last_pass;
    logic               w_pass_end;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_next_dir;
    logic [IDX_W-1:0]   w_start_first;
    logic [IDX_W-1:0]   w_pass_first;
    logic [N_OUT-1:0]   w_onehot;

    assign w_abort       = abort && (r_state != c_S_IDLE);
    assign w_accept      = start && !abort && (r_state == c_S_IDLE);
    assign w_prime_last  = r_prime - DWELL_W'(1);
    assign w_dwell_last  = (r_dwell == '0) ? '0 : (r_dwell - DWELL_W'(1));
    assign w_passes_eff  = (r_passes == '0) ? (REP_W+1)'(1) : {1'b0, r_passes};
    assign w_pass_inc    = {1'b0, r_pass_cnt} + (REP_W+1)'(1);
    assign w_last_pass   = (w_pass_inc == w_passes_eff);
    assign w_start_first = (mode == c_MODE_DESC) ? c_LAST : '0;
    assign w_pass_first  = (r_mode == c_MODE_DESC) ? c_LAST : '0;
    assign w_onehot      = N_OUT'(1) << r_idx;

    // Ping-pong turns around at the top port; r_dir=1 marks the downward leg.
    always_comb begin
        w_pass_end = (r_idx == c_LAST);
        w_next_idx = r_idx + IDX_W'(1);
        w_next_dir = r_dir;
        if (r_mode == c_MODE_DESC) begin
            w_pass_end = (r_idx == '0);
            w_next_idx = r_idx - IDX_W'(1);
        end else if (r_mode == c_MODE_PP) begin
            w_pass_end = r_dir && (r_idx == '0);
            if (r_dir || (r_idx == c_LAST)) begin
                w_next_idx = r_idx - IDX_W'(1);
                w_next_dir = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        inlet_en    = 2'b00;
        out_valve   = '0;
        chan_idx    = '0;
        sample_req  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (prime_cyc == '0) ? c_S_SETTLE : c_S_PRIME;
                end
            end
            c_S_PRIME: begin
                inlet_en  = 2'b11;
                out_valve = '1;
                busy      = 1'b1;
                if (r_cnt == w_prime_last) begin
                    w_state_nxt = c_S_SETTLE;
                end
            end
            c_S_SETTLE: begin
                inlet_en  = 2'b11;
                out_valve = w_onehot;
                chan_idx  = r_idx;
                busy      = 1'b1;
                if (r_cnt == w_dwell_last) begin
                    w_state_nxt = c_S_REQ;
                end
            end
            c_S_REQ: begin
                inlet_en   = 2'b11;
                out_valve  = w_onehot;
                chan_idx   = r_idx;
                sample_req = 1'b1;
                busy       = 1'b1;
                if (sample_ack) begin
                    w_state_nxt = (w_pass_end && w_last_pass) ? c_S_DONE : c_S_SETTLE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = c_S_IDLE;
        end
    end

    assign err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_S_IDLE;
            r_mode     <= '0;
            r_prime    <= '0;
            r_dwell    <= '0;
            r_passes   <= '0;
            r_cnt      <= '0;
            r_to_cnt   <= '0;
            r_idx      <= '0;
            r_dir      <= 1'b0;
            r_pass_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_abort) begin
                r_cnt      <= '0;
                r_to_cnt   <= '0;
                r_idx      <= '0;
                r_dir      <= 1'b0;
                r_pass_cnt <= '0;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (w_accept) begin
                            r_mode     <= mode;
                            r_prime    <= prime_cyc;
                            r_dwell    <= dwell_cyc;
                            r_passes   <= passes;
                            r_err      <= 1'b0;
                            r_cnt      <= '0;
                            r_to_cnt   <= '0;
                            r_idx      <= w_start_first;
                            r_dir      <= 1'b0;
                            r_pass_cnt <= '0;
                        end
                    end
                    c_S_PRIME, c_S_SETTLE: begin
                        if (w_state_nxt != r_state) begin
                            r_cnt    <= '0;
                            r_to_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + DWELL_W'(1);
                        end
                    end
                    c_S_REQ: begin
                        if (sample_ack) begin
                            if (w_pass_end) begin
                                r_pass_cnt <= w_pass_inc[REP_W-1:0];
                                r_idx      <= w_pass_first;
                                r_dir      <= 1'b0;
                            end else begin
                                r_idx <= w_next_idx;
                                r_dir <= w_next_dir;
                            end
                        end else if (r_to_cnt == c_TO_LAST) begin
                            r_err <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_W'(1);
                        end
                    end
                    c_S_DONE: begin
                        r_idx      <= '0;
                        r_dir      <= 1'b0;
                        r_pass_cnt <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gradient_seq_ctrl.sv
// ============================================================================
// Module   : tb_gradient_seq_ctrl
// Brief    : Randomised self-checking bench with a visit-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gradient_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, ack;
    logic [1:0]  mode;
    logic [15:0] prime_cyc, dwell_cyc;
    logic [3:0]  passes;

    logic [1:0]  inl_a, inl_b;
    logic [10:0] ov_a;
    logic [3:0]  ov_b;
    logic [3:0]  ci_a;
    logic [1:0]  ci_b;
    logic        req_a, busy_a, done_a, err_a;
    logic        req_b, busy_b, done_b, err_b;

    logic        sel;
    logic [1:0]  obs_inl;
    logic [10:0] obs_ov;
    logic [3:0]  obs_ci;
    logic        obs_req, obs_busy, obs_done, obs_err;

    int checks, errors;
    int visits[$], settles[$], exp_q[$];
    int prime_len, done_cnt, max_req_run, err_at_done;

    always #5 clk = ~clk;

    gradient_seq_ctrl #(.N_OUT(11), .DWELL_W(16), .REP_W(4), .ACK_TO(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .prime_cyc(prime_cyc), .dwell_cyc(dwell_cyc), .passes(passes),
        .inlet_en(inl_a), .out_valve(ov_a), .chan_idx(ci_a), .sample_req(req_a),
        .sample_ack(ack), .busy(busy_a), .done(done_a), .err(err_a)
    );

    gradient_seq_ctrl #(.N_OUT(4), .DWELL_W(16), .REP_W(4), .ACK_TO(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .prime_cyc(prime_cyc), .dwell_cyc(dwell_cyc), .passes(passes),
        .inlet_en(inl_b), .out_valve(ov_b), .chan_idx(ci_b), .sample_req(req_b),
        .sample_ack(ack), .busy(busy_b), .done(done_b), .err(err_b)
    );

    always_comb begin
        if (sel) begin
            obs_inl = inl_b; obs_ov = {7'd0, ov_b}; obs_ci = {2'd0, ci_b};
            obs_req = req_b; obs_busy = busy_b; obs_done = done_b; obs_err = err_b;
        end else begin
            obs_inl = inl_a; obs_ov = ov_a; obs_ci = ci_a;
            obs_req = req_a; obs_busy = busy_a; obs_done = done_a; obs_err = err_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b || done_a || done_b) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(busy_a || busy_b), 0);
    endtask

    // Drives one sequence on both DUTs and records what the selected DUT did.
    task automatic run_seq(input int m, input int p, input int d, input int ps,
                           input int ack_dly, input bit poke);
        logic [10:0] all_ones;
        int settle_run, req_run;
        bit finished;
        all_ones = sel ? 11'h00F : 11'h7FF;
        wait_idle();
        visits.delete(); settles.delete();
        prime_len = 0; done_cnt = 0; max_req_run = 0; err_at_done = 0;
        settle_run = 0; req_run = 0; finished = 0;
        mode = 2'(m); prime_cyc = 16'(p); dwell_cyc = 16'(d); passes = 4'(ps);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_clear_on_start", 32'(obs_err), 0);
        mode = 2'($urandom); prime_cyc = 16'($urandom); dwell_cyc = 16'($urandom);
        passes = 4'($urandom);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (obs_done) begin
                ack = 1'b0;
                done_cnt++;
                err_at_done = int'(obs_err);
                chk("done_busy", 32'(obs_busy), 0);
                chk("done_valves", 32'(obs_ov), 0);
                chk("done_inlet", 32'(obs_inl), 0);
                chk("done_req", 32'(obs_req), 0);
                @(negedge clk);
                chk("post_done_busy", 32'(obs_busy), 0);
                chk("post_done_pulse", 32'(obs_done), 0);
                finished = 1;
            end else begin
                chk("busy_inlet", 32'(obs_inl), 32'(obs_busy ? 2'b11 : 2'b00));
                if (obs_ov == all_ones) begin
                    prime_len++;
                    chk("prime_chan", 32'(obs_ci), 0);
                end else begin
                    chk("onehot_chan", 32'(obs_ov), 32'(1) << obs_ci);
                    if (!obs_req) settle_run++;
                end
                if (obs_req) begin
                    if (req_run == 0) begin
                        settles.push_back(settle_run);
                        settle_run = 0;
                    end
                    if (req_run == ack_dly) begin
                        ack = 1'b1;
                        visits.push_back(int'(obs_ci));
                    end else begin
                        ack = 1'b0;
                    end
                    req_run++;
                    if (req_run > max_req_run) max_req_run = req_run;
                end else begin
                    ack = 1'b0;
                    req_run = 0;
                end
                if (poke && cyc == 6) begin
                    start = 1'b1;
                    mode = 2'(m) ^ 2'b01;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        ack = 1'b0;
        start = 1'b0;
        if (!finished) chk("seq_timeout", 1, 0);
    endtask

    // Visit-order model derived directly from the per-mode traversal rules.
    task automatic verify(input int m, input int p, input int d, input int ps);
        int n, np;
        n = sel ? 4 : 11;
        np = (ps == 0) ? 1 : ps;
        exp_q.delete();
        for (int k = 0; k < np; k++) begin
            if (m == 1) begin
                for (int i = n - 1; i >= 0; i--) exp_q.push_back(i);
            end else if (m == 2) begin
                for (int i = 0; i < n; i++) exp_q.push_back(i);
                for (int i = n - 2; i >= 0; i--) exp_q.push_back(i);
            end else begin
                for (int i = 0; i < n; i++) exp_q.push_back(i);
            end
        end
        chk("n_visits", 32'(visits.size()), 32'(exp_q.size()));
        for (int i = 0; i < visits.size() && i < exp_q.size(); i++)
            chk("visit_order", 32'(visits[i]), 32'(exp_q[i]));
        chk("n_settles", 32'(settles.size()), 32'(exp_q.size()));
        foreach (settles[i]) chk("settle_len", 32'(settles[i]), 32'((d == 0) ? 1 : d));
        chk("prime_len", 32'(prime_len), 32'(p));
        chk("done_cnt", 32'(done_cnt), 1);
    endtask

    initial begin
        int m, p, d, ps, dl;
        checks = 0; errors = 0; sel = 1'b0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
        mode = '0; prime_cyc = '0; dwell_cyc = '0; passes = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(obs_busy), 0);
        chk("rst_done", 32'(obs_done), 0);
        chk("rst_err", 32'(obs_err), 0);
        chk("rst_inlet", 32'(obs_inl), 0);
        chk("rst_valves", 32'(obs_ov), 0);
        chk("rst_chan", 32'(obs_ci), 0);
        chk("rst_req", 32'(obs_req), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(0, 2, 3, 1, 1, 0);
        verify(0, 2, 3, 1);

        run_seq(2, 0, 0, 2, 1, 0);
        verify(2, 0, 0, 2);

        run_seq(0, 0, 2, 1, 100, 0);
        chk("to_req_len", 32'(max_req_run), 8);
        chk("to_err", 32'(err_at_done), 1);
        chk("to_done", 32'(done_cnt), 1);
        chk("to_visits", 32'(visits.size()), 0);
        chk("to_err_sticky", 32'(obs_err), 1);

        run_seq(1, 1, 1, 1, 0, 0);
        verify(1, 1, 1, 1);

        run_seq(0, 1, 2, 1, 2, 1);
        verify(0, 1, 2, 1);

        sel = 1'b1;
        run_seq(1, 0, 1, 1, 1, 0);
        verify(1, 0, 1, 1);

        for (int k = 0; k < 6; k++) begin
            sel = k[0];
            m = $urandom_range(0, 3); p = $urandom_range(0, 3);
            d = $urandom_range(0, 4); ps = $urandom_range(0, 2); dl = $urandom_range(0, 3);
            run_seq(m, p, d, ps, dl, 0);
            verify(m, p, d, ps);
        end
        sel = 1'b0;

        wait_idle();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(obs_busy), 0);

        mode = 2'b00; prime_cyc = 16'd0; dwell_cyc = 16'd1; passes = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20 && !obs_req; n++) @(negedge clk);
        chk("abort_in_req", 32'(obs_req), 1);
        ack = 1'b1; abort = 1'b1;
        @(negedge clk);
        ack = 1'b0; abort = 1'b0;
        chk("abort_busy", 32'(obs_busy), 0);
        chk("abort_valves", 32'(obs_ov), 0);
        chk("abort_inlet", 32'(obs_inl), 0);
        chk("abort_req", 32'(obs_req), 0);
        chk("abort_chan", 32'(obs_ci), 0);
        chk("abort_err", 32'(obs_err), 0);
        for (int n = 0; n < 3; n++) begin
            chk("abort_no_done", 32'(obs_done), 0);
            @(negedge clk);
        end

        wait_idle();
        mode = 2'b00; prime_cyc = 16'd0; dwell_cyc = 16'd5; passes = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_rst_valve", 32'(obs_ov), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(obs_busy), 0);
        chk("async_rst_valves", 32'(obs_ov), 0);
        chk("async_rst_inlet", 32'(obs_inl), 0);
        chk("async_rst_chan", 32'(obs_ci), 0);
        chk("async_rst_req", 32'(obs_req), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
